// File: rtl/match_responder_pkg.sv
// Shared definitions for the memory-match responder: FSM states, colour
// codes, PS/2 scan codes, per-level pair counts, card layouts and small
// lookup helpers used by the responder top.
package match_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOOKUP     = 3'd1,
        ST_RESP_MATCH = 3'd2,
        ST_FIN_EVAL   = 3'd3,
        ST_RESP_FIN   = 3'd4
    } state_t;

    // Card colours; 0 marks an unused slot.
    localparam logic [2:0] COL_NONE    = 3'd0;
    localparam logic [2:0] COL_RED     = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_BLUE    = 3'd3;
    localparam logic [2:0] COL_YELLOW  = 3'd4;
    localparam logic [2:0] COL_CYAN    = 3'd5;
    localparam logic [2:0] COL_MAGENTA = 3'd6;

    // PS/2 make codes of the twelve card keys.
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_Z = 8'h1A;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_V = 8'h2A;

    localparam logic [2:0] PAIRS_EASY   = 3'd2;
    localparam logic [2:0] PAIRS_MEDIUM = 3'd3;
    localparam logic [2:0] PAIRS_HARD   = 3'd6;

    // [layout][level 001/010/100][card q..v]
    localparam logic [2:0] LAYOUT_TBL [0:3][0:2][0:11] = '{
        '{ '{3'd1, 3'd2, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd1, 3'd2, 3'd3, 3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1} },
        '{ '{3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd1, 3'd1, 3'd2, 3'd0, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6} },
        '{ '{3'd3, 3'd3, 3'd0, 3'd0, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd4, 3'd5, 3'd6, 3'd0, 3'd6, 3'd5, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6} },
        '{ '{3'd5, 3'd6, 3'd0, 3'd0, 3'd5, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd2, 3'd3, 3'd1, 3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
           '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6} }
    };

    function automatic logic level_valid(input logic [2:0] lv);
        return (lv == 3'b001) || (lv == 3'b010) || (lv == 3'b100);
    endfunction

    function automatic logic [2:0] pair_count(input logic [2:0] lv);
        case (lv)
            3'b001:  return PAIRS_EASY;
            3'b010:  return PAIRS_MEDIUM;
            3'b100:  return PAIRS_HARD;
            default: return 3'd0;
        endcase
    endfunction

    // Cards that take part in a game at the given level.
    function automatic logic [11:0] level_mask(input logic [2:0] lv);
        case (lv)
            3'b001:  return 12'h033;
            3'b010:  return 12'h077;
            3'b100:  return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    // Colour of one card; 0 for no game or an index past the last card.
    function automatic logic [2:0] card_color(input logic [1:0] lay,
                                              input logic [2:0] lv,
                                              input logic [3:0] idx);
        if (idx > 4'd11) begin
            return COL_NONE;
        end else begin
            case (lv)
                3'b001:  return LAYOUT_TBL[lay][0][idx];
                3'b010:  return LAYOUT_TBL[lay][1][idx];
                3'b100:  return LAYOUT_TBL[lay][2][idx];
                default: return COL_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/match_responder_scancode.sv
// scancode_to_index: combinational decode of a PS/2 make code to a card
// index 0..11 (q,w,e,r,a,s,d,f,z,x,c,v).
//   code  in  8  scan code
//   index out 4  card index (0 when invalid)
//   valid out 1  code is one of the twelve card keys
module scancode_to_index
    import match_responder_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] index,
    output logic       valid
);

    // Table decode of the twelve card keys.
    always_comb begin
        index = 4'd0;
        valid = 1'b1;
        case (code)
            SC_Q:    index = 4'd0;
            SC_W:    index = 4'd1;
            SC_E:    index = 4'd2;
            SC_R:    index = 4'd3;
            SC_A:    index = 4'd4;
            SC_S:    index = 4'd5;
            SC_D:    index = 4'd6;
            SC_F:    index = 4'd7;
            SC_Z:    index = 4'd8;
            SC_X:    index = 4'd9;
            SC_C:    index = 4'd10;
            SC_V:    index = 4'd11;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/match_responder.sv
// match_responder: judges card-pair selections of a memory game and reports
// game completion through level-held request/response handshakes.
//   clk, reset            clock, synchronous active-high reset
//   level                 one-hot difficulty (001/010/100), else no game
//   key_a, key_b          scan codes of the two selected cards
//   checkMatch            held request to judge key_a/key_b
//   checkFinish           held request to report completion
//   isCorrect             0 none, 1 match, 2 no match
//   isFinished            0 none, 1 all pairs found, 2 pairs remain
//   matched, pairs_done   per-card matched flags and matched-pair count
//   disp_index/disp_color combinational colour read of the active layout
module match_responder
    import match_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  level,
    input  logic [7:0]  key_a,
    input  logic [7:0]  key_b,
    input  logic        checkMatch,
    input  logic        checkFinish,
    output logic [1:0]  isCorrect,
    output logic [1:0]  isFinished,
    output logic [11:0] matched,
    output logic [2:0]  pairs_done,
    input  logic [3:0]  disp_index,
    output logic [2:0]  disp_color
);

    state_t      state_r;
    logic [1:0]  lay_cnt_r;
    logic [1:0]  layout_sel_r;
    logic [2:0]  lvl_r;
    logic [7:0]  ka_r;
    logic [7:0]  kb_r;

    logic [3:0]  idx_a_s;
    logic [3:0]  idx_b_s;
    logic        vld_a_s;
    logic        vld_b_s;
    logic        level_ok_s;
    logic        start_s;
    logic        correct_s;
    logic        pair_full_s;
    logic [11:0] mask_s;

    scancode_to_index u_dec_a (.code(ka_r), .index(idx_a_s), .valid(vld_a_s));
    scancode_to_index u_dec_b (.code(kb_r), .index(idx_b_s), .valid(vld_b_s));

    assign disp_color = card_color(layout_sel_r, lvl_r, disp_index);

    // Pair judgement on the registered keys against the latched level/layout.
    always_comb begin
        level_ok_s  = level_valid(level);
        // lvl_r is cleared whenever level is invalid, so zero means "no game yet".
        start_s     = level_ok_s && (lvl_r == 3'b000);
        mask_s      = level_mask(lvl_r);
        pair_full_s = (pairs_done >= pair_count(lvl_r));
        correct_s   = vld_a_s && vld_b_s
                   && mask_s[idx_a_s] && mask_s[idx_b_s]
                   && (idx_a_s != idx_b_s)
                   && !matched[idx_a_s] && !matched[idx_b_s]
                   && (card_color(layout_sel_r, lvl_r, idx_a_s) ==
                       card_color(layout_sel_r, lvl_r, idx_b_s));
    end

    // Game state, response FSM and layout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            lay_cnt_r    <= 2'd0;
            layout_sel_r <= 2'd0;
            lvl_r        <= 3'b000;
            ka_r         <= 8'h00;
            kb_r         <= 8'h00;
            isCorrect    <= 2'd0;
            isFinished   <= 2'd0;
            matched      <= 12'h000;
            pairs_done   <= 3'd0;
        end else begin
            lay_cnt_r <= lay_cnt_r + 2'd1;
            if (!level_ok_s) begin
                state_r    <= ST_IDLE;
                lvl_r      <= 3'b000;
                isCorrect  <= 2'd0;
                isFinished <= 2'd0;
                matched    <= 12'h000;
                pairs_done <= 3'd0;
            end else begin
                // A valid-to-valid level change leaves lvl_r untouched.
                if (start_s) begin
                    lvl_r        <= level;
                    layout_sel_r <= lay_cnt_r;
                    matched      <= 12'h000;
                    pairs_done   <= 3'd0;
                end else begin
                    lvl_r <= lvl_r;
                end
                case (state_r)
                    ST_IDLE: begin
                        if (checkMatch) begin
                            ka_r    <= key_a;
                            kb_r    <= key_b;
                            state_r <= ST_LOOKUP;
                        end else if (checkFinish) begin
                            state_r <= ST_FIN_EVAL;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_LOOKUP: begin
                        state_r <= ST_RESP_MATCH;
                        if (correct_s) begin
                            isCorrect          <= 2'd1;
                            matched[idx_a_s]   <= 1'b1;
                            matched[idx_b_s]   <= 1'b1;
                            if (!pair_full_s) begin
                                pairs_done <= pairs_done + 3'd1;
                            end else begin
                                pairs_done <= pairs_done;
                            end
                        end else begin
                            isCorrect <= 2'd2;
                        end
                    end
                    ST_RESP_MATCH: begin
                        if (!checkMatch) begin
                            isCorrect <= 2'd0;
                            state_r   <= ST_IDLE;
                        end else begin
                            state_r <= ST_RESP_MATCH;
                        end
                    end
                    ST_FIN_EVAL: begin
                        isFinished <= (pairs_done == pair_count(lvl_r)) ? 2'd1 : 2'd2;
                        state_r    <= ST_RESP_FIN;
                    end
                    ST_RESP_FIN: begin
                        if (!checkFinish) begin
                            isFinished <= 2'd0;
                            state_r    <= ST_IDLE;
                        end else begin
                            state_r <= ST_RESP_FIN;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        isCorrect  <= 2'd0;
                        isFinished <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
